dmem_arbiter: RTL and testbench

- Shares the single-port synchronous data RAM between two requesters.
  - Port 0: the CPU load/store path (mem_addr / mem_write_data / wren / mem_read_data).
  - Port 1: a second master, e.g. the VGA/keyboard buffer engine or a debug loader.
- Sits between the cpu top and the RAM macro.
- Serialises single-beat accesses with a round-robin grant and returns read data with a valid pulse.

---
 rtl/dmem_arb_pkg.sv | 18 +
 rtl/rr_pick2.sv | 21 ++
 rtl/dmem_arbiter.sv | 132 +++++++++++++
 tb/tb_dmem_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
//   - arb_state_e : arbiter FSM states
//   - DEF_*       : default widths used as module parameter defaults
//   - NUM_PORTS   : number of requesters sharing the RAM
package dmem_arb_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_RAM_AW = 10;
  localparam int NUM_PORTS  = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker (purely combinational).
//   req   : request vector, bit i = port i requesting
//   last  : port granted most recently
//   valid : at least one request present
//   sel   : chosen port; on a tie the port that was not granted last wins
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 last,
  output logic                 valid,
  output logic                 sel
);

  always_comb begin
    valid = |req;
    // A lone request selects its own port; only a tie consults history.
    sel   = (req == 2'b11) ? ~last : req[1];
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port synchronous RAM between two single-beat requesters.
//   clk, rst            : clock, synchronous active-high reset
//   req/we/addr/wdata N : requester N access (req held until gntN)
//   gntN                : one-cycle pulse, access accepted
//   rvalidN / rdataN    : one-cycle read-data pulse; rdataN holds otherwise
//   ram_addr/ram_wdata/ram_wren : RAM macro side, word addressed
//   ram_rdata           : RAM read data, one cycle after the address
// A write takes IDLE->ACCESS (2 cycles), a read IDLE->ACCESS->RESP (3 cycles).
// All outputs decode from registered state; ram_rdata is forwarded to the
// selected port's rdata during RESP.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int RAM_AW = DEF_RAM_AW
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,

  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,

  output logic [RAM_AW-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_rdata
);

  arb_state_e        state, state_nxt;
  logic              last_gnt;
  logic              sel_q;
  logic              we_q;
  logic [RAM_AW-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  logic              pick_valid;
  logic              pick_sel;

  // Byte-offset bits and bits above the RAM size are dropped on purpose:
  // misaligned addresses truncate and large addresses wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr0[1:0], addr0[ADDR_W-1:RAM_AW+2],
                              addr1[1:0], addr1[ADDR_W-1:RAM_AW+2]};

  rr_pick2 u_pick (
    .req   ({req1, req0}),
    .last  (last_gnt),
    .valid (pick_valid),
    .sel   (pick_sel)
  );

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  // NOTE: the default assignment first keeps always_comb from inferring a
  // latch on any path that does not assign state_nxt.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (pick_valid) state_nxt = ACCESS;
      ACCESS:  state_nxt = we_q ? IDLE : RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Access latches: captured once in IDLE and held for the whole access,
  // so requester changes after acceptance have no effect.
  // NOTE: these datapath registers are reset (unlike a RAM array) because
  // ram_addr/ram_wdata must read as zero right after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= 1'b1;  // port 0 wins the first tie
      sel_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else if (state == IDLE && pick_valid) begin
      last_gnt <= pick_sel;
      sel_q    <= pick_sel;
      we_q     <= pick_sel ? we1    : we0;
      addr_q   <= pick_sel ? addr1[RAM_AW+1:2] : addr0[RAM_AW+1:2];
      wdata_q  <= pick_sel ? wdata1 : wdata0;
    end
  end

  // Read-data hold registers; only the port that issued the read updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (rvalid0) rdata0_q <= ram_rdata;
      if (rvalid1) rdata1_q <= ram_rdata;
    end
  end

  // Output decode.
  always_comb begin
    gnt0      = (state == ACCESS) && !sel_q;
    gnt1      = (state == ACCESS) &&  sel_q;
    rvalid0   = (state == RESP)   && !sel_q;
    rvalid1   = (state == RESP)   &&  sel_q;
    ram_wren  = (state == ACCESS) &&  we_q;
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
    rdata0    = rvalid0 ? ram_rdata : rdata0_q;
    rdata1    = rvalid1 ? ram_rdata : rdata1_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural 1024-word RAM
// (registered address, one-cycle read latency).
module tb_dmem_arbiter;

  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] CF = 32'hCAFEF00D;
  localparam logic [31:0] D12 = 32'h12345678;

  logic        clk;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        gnt0, rvalid0, gnt1, rvalid1;
  logic [31:0] rdata0, rdata1;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_wren;
  logic [31:0] ram_rdata;

  int n_checks = 0;
  int n_err    = 0;

  dmem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .we0       (we0),
    .addr0     (addr0),
    .wdata0    (wdata0),
    .gnt0      (gnt0),
    .rvalid0   (rvalid0),
    .rdata0    (rdata0),
    .req1      (req1),
    .we1       (we1),
    .addr1     (addr1),
    .wdata1    (wdata1),
    .gnt1      (gnt1),
    .rvalid1   (rvalid1),
    .rdata1    (rdata1),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_wren  (ram_wren),
    .ram_rdata (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model
  logic [31:0] mem [1024];
  logic [9:0]  ram_addr_q;
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    ram_addr_q = '0;
  end
  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_wdata;
    ram_addr_q <= ram_addr;
  end
  assign ram_rdata = mem[ram_addr_q];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " gnt0"},      {31'd0, gnt0},     0);
    check({tag, " gnt1"},      {31'd0, gnt1},     0);
    check({tag, " rvalid0"},   {31'd0, rvalid0},  0);
    check({tag, " rvalid1"},   {31'd0, rvalid1},  0);
    check({tag, " ram_wren"},  {31'd0, ram_wren}, 0);
    check({tag, " ram_addr"},  {22'd0, ram_addr}, 0);
    check({tag, " ram_wdata"}, ram_wdata,         0);
    check({tag, " rdata0"},    rdata0,            0);
    check({tag, " rdata1"},    rdata1,            0);
  endtask

  // One row = inputs driven for one cycle + outputs expected in that cycle.
  // Outputs in a row reflect the inputs of the previous row.
  typedef struct {
    logic        rst;
    logic        req0, we0;
    logic [31:0] addr0, wdata0;
    logic        req1, we1;
    logic [31:0] addr1, wdata1;
    logic        chk;
    logic        gnt0, gnt1, rv0, rv1;
    logic [31:0] rd0, rd1;
    logic        wren;
    logic [9:0]  raddr;
    logic [31:0] wdat;
  } vec_t;

  vec_t tbl [19];

  int g_port [$];
  int g_cyc  [$];

  initial begin
    rst = 1'b1;
    idle_inputs();

    //            rst r0 w0 addr0     wdata0  r1 w1 addr1     wdata1  chk g0 g1 v0 v1 rd0 rd1 wren raddr wdat
    tbl[0]  = '{1, 0, 0, 32'h0,    0,      0, 0, 32'h0,    0,      0,  0, 0, 0, 0, 0,  0,  0,   0,    0};
    tbl[1]  = '{0, 0, 0, 32'h0,    0,      0, 0, 32'h0,    0,      1,  0, 0, 0, 0, 0,  0,  0,   0,    0};
    tbl[2]  = '{0, 1, 1, 32'h10,   DB,     0, 0, 32'h0,    0,      1,  0, 0, 0, 0, 0,  0,  0,   0,    0};
    tbl[3]  = '{0, 1, 1, 32'h10,   DB,     0, 0, 32'h0,    0,      1,  1, 0, 0, 0, 0,  0,  1,   4,    DB};
    tbl[4]  = '{0, 0, 0, 32'h0,    0,      0, 0, 32'h0,    0,      1,  0, 0, 0, 0, 0,  0,  0,   4,    DB};
    tbl[5]  = '{0, 0, 0, 32'h0,    0,      1, 0, 32'h10,   0,      1,  0, 0, 0, 0, 0,  0,  0,   4,    DB};
    tbl[6]  = '{0, 0, 0, 32'h0,    0,      1, 0, 32'h10,   0,      1,  0, 1, 0, 0, 0,  0,  0,   4,    0};
    tbl[7]  = '{0, 0, 0, 32'h0,    0,      0, 0, 32'h0,    0,      1,  0, 0, 0, 1, 0,  DB, 0,   4,    0};
    tbl[8]  = '{0, 0, 0, 32'h0,    0,      0, 0, 32'h0,    0,      1,  0, 0, 0, 0, 0,  DB, 0,   4,    0};
    tbl[9]  = '{0, 1, 1, 32'h1004, CF,     0, 0, 32'h0,    0,      1,  0, 0, 0, 0, 0,  DB, 0,   4,    0};
    tbl[10] = '{0, 1, 1, 32'h1004, CF,     0, 0, 32'h0,    0,      1,  1, 0, 0, 0, 0,  DB, 1,   1,    CF};
    tbl[11] = '{0, 1, 0, 32'h4,    0,      0, 0, 32'h0,    0,      1,  0, 0, 0, 0, 0,  DB, 0,   1,    CF};
    tbl[12] = '{0, 1, 0, 32'h4,    0,      0, 0, 32'h0,    0,      1,  1, 0, 0, 0, 0,  DB, 0,   1,    0};
    tbl[13] = '{0, 0, 0, 32'h0,    0,      0, 0, 32'h0,    0,      1,  0, 0, 1, 0, CF, DB, 0,   1,    0};
    tbl[14] = '{0, 0, 0, 32'h0,    0,      0, 0, 32'h0,    0,      1,  0, 0, 0, 0, CF, DB, 0,   1,    0};
    tbl[15] = '{0, 0, 0, 32'h0,    0,      1, 0, 32'h1007, 0,      1,  0, 0, 0, 0, CF, DB, 0,   1,    0};
    // request changes while in ACCESS must be ignored
    tbl[16] = '{0, 0, 0, 32'h0,    0,      1, 1, 32'h20,   32'h55, 1,  0, 1, 0, 0, CF, DB, 0,   1,    0};
    tbl[17] = '{0, 0, 0, 32'h0,    0,      0, 0, 32'h0,    0,      1,  0, 0, 0, 1, CF, CF, 0,   1,    0};
    tbl[18] = '{0, 0, 0, 32'h0,    0,      0, 0, 32'h0,    0,      1,  0, 0, 0, 0, CF, CF, 0,   1,    0};

    for (int i = 0; i < 19; i++) begin
      string t;
      t = $sformatf("row%0d", i);
      rst = tbl[i].rst;
      req0 = tbl[i].req0; we0 = tbl[i].we0; addr0 = tbl[i].addr0; wdata0 = tbl[i].wdata0;
      req1 = tbl[i].req1; we1 = tbl[i].we1; addr1 = tbl[i].addr1; wdata1 = tbl[i].wdata1;
      @(negedge clk);
      if (tbl[i].chk) begin
        check({t, " gnt0"},      {31'd0, gnt0},     {31'd0, tbl[i].gnt0});
        check({t, " gnt1"},      {31'd0, gnt1},     {31'd0, tbl[i].gnt1});
        check({t, " rvalid0"},   {31'd0, rvalid0},  {31'd0, tbl[i].rv0});
        check({t, " rvalid1"},   {31'd0, rvalid1},  {31'd0, tbl[i].rv1});
        check({t, " rdata0"},    rdata0,            tbl[i].rd0);
        check({t, " rdata1"},    rdata1,            tbl[i].rd1);
        check({t, " ram_wren"},  {31'd0, ram_wren}, {31'd0, tbl[i].wren});
        check({t, " ram_addr"},  {22'd0, ram_addr}, {22'd0, tbl[i].raddr});
        check({t, " ram_wdata"}, ram_wdata,         tbl[i].wdat);
      end
      next_cycle();
    end

    // ---- Fairness: both ports read continuously from reset ----
    rst = 1; idle_inputs();
    @(negedge clk);
    next_cycle();
    rst = 0;
    req0 = 1; we0 = 0; addr0 = 32'h10;
    req1 = 1; we1 = 0; addr1 = 32'h1004;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (gnt0 && gnt1) check($sformatf("fair c%0d both gnt", c), 1, 0);
      if (gnt0) begin g_port.push_back(0); g_cyc.push_back(c); end
      if (gnt1) begin g_port.push_back(1); g_cyc.push_back(c); end
      if (rvalid0) check($sformatf("fair c%0d rdata0", c), rdata0, DB);
      if (rvalid1) check($sformatf("fair c%0d rdata1", c), rdata1, CF);
      next_cycle();
    end
    check("fair grant count", g_port.size(), 7);
    for (int g = 0; g < 7 && g < g_port.size(); g++) begin
      check($sformatf("fair grant%0d port", g), g_port[g], g % 2);
      check($sformatf("fair grant%0d cycle", g), g_cyc[g], 1 + 3 * g);
    end

    // ---- Reset during ACCESS of a write ----
    rst = 1; idle_inputs();
    @(negedge clk);
    next_cycle();
    rst = 0; req0 = 1; we0 = 1; addr0 = 32'h20; wdata0 = D12;
    @(negedge clk);
    check_all_zero("rstw pre");
    next_cycle();
    rst = 1;                               // sampled at the ACCESS edge
    @(negedge clk);
    check("rstw gnt0",     {31'd0, gnt0},     1);
    check("rstw ram_wren", {31'd0, ram_wren}, 1);
    check("rstw ram_addr", {22'd0, ram_addr}, 8);
    next_cycle();
    rst = 0; idle_inputs();
    @(negedge clk);
    check_all_zero("rstw post");
    next_cycle();
    req1 = 1; we1 = 0; addr1 = 32'h20;
    @(negedge clk);
    check("rstw no gnt0", {31'd0, gnt0}, 0);
    next_cycle();
    @(negedge clk);
    check("rstw rd gnt1",     {31'd0, gnt1},     1);
    check("rstw rd ram_addr", {22'd0, ram_addr}, 8);
    next_cycle();
    req1 = 0;
    @(negedge clk);
    check("rstw rd rvalid1", {31'd0, rvalid1}, 1);
    check("rstw rd rdata1",  rdata1,           D12);

    // ---- Reset during RESP of a read ----
    next_cycle();
    req0 = 1; we0 = 0; addr0 = 32'h20;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    check("rstr gnt0", {31'd0, gnt0}, 1);
    next_cycle();
    req0 = 0; rst = 1;
    @(negedge clk);
    check("rstr rvalid0", {31'd0, rvalid0}, 1);
    check("rstr rdata0",  rdata0,           D12);
    next_cycle();
    rst = 0;
    @(negedge clk);
    check_all_zero("rstr post");
    next_cycle();
    req0 = 1; we0 = 0; addr0 = 32'h10;
    req1 = 1; we1 = 0; addr1 = 32'h1004;
    @(negedge clk);
    check("rstr quiet rvalid0", {31'd0, rvalid0}, 0);
    check("rstr quiet rvalid1", {31'd0, rvalid1}, 0);
    next_cycle();
    @(negedge clk);
    check("tie gnt0", {31'd0, gnt0}, 1);
    check("tie gnt1", {31'd0, gnt1}, 0);
    next_cycle();
    req0 = 0;
    @(negedge clk);
    check("tie rvalid0", {31'd0, rvalid0}, 1);
    check("tie rdata0",  rdata0,           DB);
    next_cycle();
    @(negedge clk);
    check("tie idle gnt1", {31'd0, gnt1}, 0);
    next_cycle();
    @(negedge clk);
    check("tie second gnt1", {31'd0, gnt1}, 1);
    next_cycle();
    req1 = 0;
    @(negedge clk);
    check("tie rvalid1", {31'd0, rvalid1}, 1);
    check("tie rdata1",  rdata1,           CF);
    check("tie rdata0 hold", rdata0,       DB);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
